// File: rtl/mem_resp_model_if.sv
// Request/response bus of the memory response model.
// master drives requests and observes ready/responses; slave is the memory.
// err_out exists only when MEM_RESP_ERR_EN is defined.
interface mem_resp_model_if;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic        wen_in;
  logic        ren_in;
  logic        ready_out;
  logic [15:0] data_out;
  logic        valid_out;
`ifdef MEM_RESP_ERR_EN
  logic        err_out;
`endif

  modport master (
    output addr_in, data_in, wen_in, ren_in,
`ifdef MEM_RESP_ERR_EN
    input  err_out,
`endif
    input  ready_out, data_out, valid_out
  );

  modport slave (
    input  addr_in, data_in, wen_in, ren_in,
`ifdef MEM_RESP_ERR_EN
    output err_out,
`endif
    output ready_out, data_out, valid_out
  );
endinterface

// File: rtl/mem_resp_model.sv
// Purpose: DEPTH x 16-bit memory that zeroes itself after reset, then serves reads/writes.
// Latency: read response exactly RD_LAT enabled cycles after acceptance; writes take effect next edge.
// Backpressure: none once ready_out=1; requests while ready_out=0 are dropped. Macro MEM_RESP_ERR_EN adds err_out.
module mem_resp_model #(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  mem_resp_model_if.slave    bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [AW-1:0]     init_cnt;
  logic              ready_r;

  logic [15:0]       mem [DEPTH];

  logic [RD_LAT-1:0] pipe_vld;
  logic [15:0]       pipe_dat [RD_LAT];
`ifdef MEM_RESP_ERR_EN
  logic [RD_LAT-1:0] pipe_err;
`endif

  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic [AW-1:0]     mem_idx;

  assign in_range = bus.addr_in < DEPTH_W;
  assign mem_idx  = bus.addr_in[AW-1:0];
  // Flush drops a read presented in the same cycle; writes are unaffected by flush.
  assign rd_acc   = (state == RUN) && clk_en && bus.ren_in && !flush;
  assign wr_acc   = (state == RUN) && clk_en && bus.wen_in && in_range;

  // Zeroing-pass sequencer: one word per enabled cycle, then hand over to RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
      ready_r  <= 1'b0;
    end else if (clk_en && state == INIT) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == AW'(DEPTH - 1)) begin
        state   <= RUN;
        ready_r <= 1'b1;
      end
    end
  end

  // Single write port shared by the zeroing pass and accepted writes; no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (reset && clk_en) begin
      if (state == INIT) begin
        mem[init_cnt] <= '0;
      end else if (wr_acc) begin
        mem[mem_idx] <= bus.data_in;
      end
    end
  end

  // Response pipeline: stage 0 captures the pre-write word, later stages shift; invalid slots carry zero data.
  always_ff @(posedge clk) begin
    if (!reset || (clk_en && flush)) begin
      pipe_vld <= '0;
`ifdef MEM_RESP_ERR_EN
      pipe_err <= '0;
`endif
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_dat[i] <= '0;
      end
    end else if (clk_en) begin
      pipe_vld[0] <= rd_acc;
      pipe_dat[0] <= (rd_acc && in_range) ? mem[mem_idx] : 16'h0000;
`ifdef MEM_RESP_ERR_EN
      pipe_err[0] <= rd_acc && !in_range;
`endif
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
`ifdef MEM_RESP_ERR_EN
        pipe_err[i] <= pipe_err[i-1];
`endif
      end
    end
  end

  assign bus.ready_out = ready_r;
  assign bus.valid_out = pipe_vld[RD_LAT-1];
  assign bus.data_out  = pipe_dat[RD_LAT-1];
`ifdef MEM_RESP_ERR_EN
  assign bus.err_out   = pipe_err[RD_LAT-1];
`endif

endmodule

// File: tb/tb_mem_resp_model.sv
// Bench for mem_resp_model: directed scenarios plus randomized traffic,
// all checked against a transaction-level model (memory array + timed response queue).
// Honours MEM_RESP_ERR_EN for the err_out checks.
module tb_mem_resp_model;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic clk_en = 1'b0;
  logic flush  = 1'b0;

  mem_resp_model_if bus ();

  mem_resp_model #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint      due;
    logic [15:0] dat;
    bit          err;
  } resp_t;

  logic [15:0] mem_m [DEPTH];
  resp_t       rq [$];
  bit          model_live = 0;
  bit          rdy_m      = 0;
  int          init_seen  = 0;
  longint      ecnt       = 0;
  bit          exp_vld    = 0;
  logic [15:0] exp_dat    = '0;
  bit          exp_err    = 0;

  always @(posedge clk) begin
    if (!reset) begin
      model_live = 1;
      rdy_m      = 0;
      init_seen  = 0;
      rq.delete();
      exp_vld    = 0;
      exp_dat    = '0;
      exp_err    = 0;
    end else if (model_live && clk_en) begin
      ecnt++;
      if (!rdy_m) begin
        init_seen++;
        if (init_seen == DEPTH) begin
          rdy_m = 1;
          foreach (mem_m[i]) mem_m[i] = '0;
        end
      end else begin
        if (flush) begin
          rq.delete();
        end else if (bus.ren_in) begin
          resp_t r;
          r.due = ecnt + RD_LAT - 1;
          r.err = !(int'(bus.addr_in) < DEPTH);
          r.dat = r.err ? 16'h0000 : mem_m[int'(bus.addr_in)];
          rq.push_back(r);
        end
        if (bus.wen_in && int'(bus.addr_in) < DEPTH) mem_m[int'(bus.addr_in)] = bus.data_in;
      end
      if (rq.size() > 0 && rq[0].due == ecnt) begin
        exp_vld = 1;
        exp_dat = rq[0].dat;
        exp_err = rq[0].err;
        void'(rq.pop_front());
      end else begin
        exp_vld = 0;
        exp_dat = '0;
        exp_err = 0;
      end
    end
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      chk("ready_out", bus.ready_out, rdy_m);
      chk("valid_out", bus.valid_out, exp_vld);
      chk("data_out",  bus.data_out,  exp_dat);
`ifdef MEM_RESP_ERR_EN
      chk("err_out",   bus.err_out,   exp_err);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen_in  = 1'b0;
    bus.ren_in  = 1'b0;
    bus.addr_in = '0;
    bus.data_in = '0;
  endtask

  task automatic req(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d);
    bus.wen_in  = w;
    bus.ren_in  = r;
    bus.addr_in = a;
    bus.data_in = d;
    step();
    idle();
  endtask

  task automatic read_expect(input logic [15:0] a, input logic [15:0] e, input string name);
    req(1'b0, 1'b1, a, 16'h0000);
    repeat (RD_LAT - 1) step();
    chk({name, "_vld"}, bus.valid_out, 1'b1);
    chk(name, bus.data_out, e);
  endtask

  // Counts cycles with ready_out=0 after a reset edge; optionally stalls clk_en for 3 cycles.
  task automatic count_init(input int stall_at, output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (bus.ready_out === 1'b1) break;
      n++;
      clk_en = (stall_at >= 0 && n >= stall_at && n < stall_at + 3) ? 1'b0 : 1'b1;
      step();
    end
    clk_en = 1'b1;
  endtask

  initial begin
    int n;
    idle();
    reset  = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Zeroing pass length, then reads of zeroed memory
    count_init(-1, n);
    chk("init_cycles", n, DEPTH);
    read_expect(16'h0037, 16'h0000, "rd_37_zero");

    // Write then read next cycle
    req(1'b1, 1'b0, 16'd5, 16'hBEEF);
    read_expect(16'd5, 16'hBEEF, "rd_after_wr");

    // Same-cycle read and write: read sees old data
    req(1'b1, 1'b1, 16'd5, 16'h1234);
    repeat (RD_LAT - 1) step();
    chk("rbw_vld", bus.valid_out, 1'b1);
    chk("rbw_old", bus.data_out, 16'hBEEF);
    read_expect(16'd5, 16'h1234, "rbw_new");

    // Out-of-range read and write
    read_expect(16'h0400, 16'h0000, "oob_rd");
`ifdef MEM_RESP_ERR_EN
    chk("oob_err", bus.err_out, 1'b1);
`endif
    req(1'b1, 1'b0, 16'h0400, 16'hDEAD);
    read_expect(16'h0000, 16'h0000, "oob_wr_alias");

    // Back-to-back reads followed by a flush
    req(1'b1, 1'b0, 16'd1, 16'h1111);
    req(1'b1, 1'b0, 16'd2, 16'h2222);
    req(1'b1, 1'b0, 16'd3, 16'h3333);
    bus.ren_in = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      bus.addr_in = 16'(a);
      step();
    end
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_quiet", bus.valid_out, 1'b0);
      step();
    end
    read_expect(16'd1, 16'h1111, "reread_1");
    read_expect(16'd2, 16'h2222, "reread_2");
    read_expect(16'd3, 16'h3333, "reread_3");

    // Read in flight frozen by clk_en=0 for 3 cycles
    req(1'b1, 1'b0, 16'd9, 16'hA5A5);
    req(1'b0, 1'b1, 16'd9, 16'h0000);
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("frozen_vld", bus.valid_out, 1'b0);
      step();
    end
    clk_en = 1'b1;
    step();
    chk("thaw_vld", bus.valid_out, 1'b1);
    chk("thaw_dat", bus.data_out, 16'hA5A5);

    // Reset mid-RUN, stall during the zeroing pass
    reset = 1'b0;
    step();
    reset = 1'b1;
    count_init(100, n);
    chk("init_stalled", n, DEPTH + 3);
    read_expect(16'd9, 16'h0000, "rd_after_rezero");

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int sel;
      reset  = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
      clk_en = ($urandom_range(0, 99) < 85);
      flush  = ($urandom_range(0, 99) < 5);
      bus.wen_in  = $urandom_range(0, 1);
      bus.ren_in  = $urandom_range(0, 1);
      bus.data_in = 16'($urandom);
      sel = $urandom_range(0, 99);
      if (sel < 90)      bus.addr_in = 16'($urandom_range(0, 15));
      else if (sel < 95) bus.addr_in = 16'($urandom_range(0, DEPTH - 1));
      else               bus.addr_in = 16'($urandom_range(DEPTH, 65535));
      step();
    end

    reset  = 1'b1;
    clk_en = 1'b1;
    flush  = 1'b0;
    idle();
    repeat (RD_LAT + 2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
